// File: rtl/chacha_pkg.sv
// Shared types and helpers for the ChaCha round scheduler.
// State enum, index widths and the diagonal rotate used by the QR indexer.
package chacha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FF,
        ST_DONE
    } state_e;

    localparam int WORD_IDX_W   = 4;
    localparam int QR_PER_ROUND = 4;

    // (i + k) & 3 falls out of 2-bit wraparound
    function automatic logic [1:0] diag_rot(
        input logic [1:0] i,
        input logic [1:0] k
    );
        return i + k;
    endfunction

endpackage

// File: rtl/chacha_qr_index.sv
// Word-index generator for one quarter-round of the 4x4 ChaCha state.
// Column rounds use the column; diagonal rounds rotate rows 1..3.
module chacha_qr_index
    import chacha_pkg::*;
(
    input  logic                  odd_i,
    input  logic [1:0]            sel_i,
    output logic [WORD_IDX_W-1:0] a_o,
    output logic [WORD_IDX_W-1:0] b_o,
    output logic [WORD_IDX_W-1:0] c_o,
    output logic [WORD_IDX_W-1:0] d_o
);

    always_comb begin
        a_o = {2'd0, sel_i};
        b_o = {2'd1, odd_i ? diag_rot(sel_i, 2'd1) : sel_i};
        c_o = {2'd2, odd_i ? diag_rot(sel_i, 2'd2) : sel_i};
        d_o = {2'd3, odd_i ? diag_rot(sel_i, 2'd3) : sel_i};
    end

endmodule

// File: rtl/chacha_round_sched.sv
// ChaCha block sequencer: QR index schedule, optional feed-forward, host gating.
// Define CHACHA_FEEDFORWARD_EN to include the 16-cycle feed-forward state.
module chacha_round_sched
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int RCNT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  host_en,
    output logic                  qr_valid,
    input  logic                  qr_ready,
    output logic [WORD_IDX_W-1:0] qr_a,
    output logic [WORD_IDX_W-1:0] qr_b,
    output logic [WORD_IDX_W-1:0] qr_c,
    output logic [WORD_IDX_W-1:0] qr_d,
    output logic [RCNT_W-1:0]     round,
    output logic                  ff_valid,
    output logic [WORD_IDX_W-1:0] ff_idx
);

    localparam logic [RCNT_W-1:0] LAST_ROUND = RCNT_W'(ROUNDS - 1);
    localparam logic [1:0]        LAST_SEL   = 2'(QR_PER_ROUND - 1);

    state_e            state_q, state_d;
    logic [RCNT_W-1:0] round_q, round_d;
    logic [1:0]        sel_q, sel_d;
    logic              xfer;
    logic              wrap;

`ifdef CHACHA_FEEDFORWARD_EN
    logic [WORD_IDX_W-1:0] ff_q, ff_d;
`endif

    assign xfer = (state_q == ST_RUN) && qr_ready;
    assign wrap = (sel_q == LAST_SEL);

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        sel_d   = sel_q;
`ifdef CHACHA_FEEDFORWARD_EN
        ff_d    = ff_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                round_d = '0;
                sel_d   = '0;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (xfer) begin
                    sel_d = sel_q + 2'd1;
                    if (wrap && round_q == LAST_ROUND) begin
`ifdef CHACHA_FEEDFORWARD_EN
                        state_d = ST_FF;
`else
                        state_d = ST_DONE;
`endif
                    end else if (wrap) begin
                        round_d = round_q + RCNT_W'(1);
                    end
                end
            end
`ifdef CHACHA_FEEDFORWARD_EN
            ST_FF: begin
                ff_d = ff_q + 4'd1;
                if (ff_q == 4'hF) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                round_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            sel_q   <= '0;
`ifdef CHACHA_FEEDFORWARD_EN
            ff_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            sel_q   <= sel_d;
`ifdef CHACHA_FEEDFORWARD_EN
            ff_q    <= ff_d;
`endif
        end
    end

    chacha_qr_index u_idx (
        .odd_i (round_q[0]),
        .sel_i (sel_q),
        .a_o   (qr_a),
        .b_o   (qr_b),
        .c_o   (qr_c),
        .d_o   (qr_d)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign host_en  = !busy;
    assign qr_valid = (state_q == ST_RUN);
    assign round    = round_q;

`ifdef CHACHA_FEEDFORWARD_EN
    assign ff_valid = (state_q == ST_FF);
    assign ff_idx   = ff_q;
`else
    assign ff_valid = 1'b0;
    assign ff_idx   = '0;
`endif

endmodule

// File: tb/tb_chacha_round_sched.sv
// Directed bench for chacha_round_sched (20-round top plus an 8-round copy).
// Expected latency follows CHACHA_FEEDFORWARD_EN when defined for the build.
module tb_chacha_round_sched;

`ifdef CHACHA_FEEDFORWARD_EN
    localparam int FFN = 16;
`else
    localparam int FFN = 0;
`endif

    localparam logic [15:0] TBL [8] = '{
        16'h048C, 16'h159D, 16'h26AE, 16'h37BF,
        16'h05AF, 16'h16BC, 16'h278D, 16'h349E
    };

    logic       clk = 1'b0;
    logic       rst_n, start, qr_ready;
    logic       busy, done, host_en, qr_valid, ff_valid;
    logic [3:0] qr_a, qr_b, qr_c, qr_d, ff_idx;
    logic [4:0] round;
    logic       b8, d8, h8, v8, f8;
    logic [3:0] a8, bb8, c8, dd8, fi8;
    logic [4:0] r8;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    chacha_round_sched #(.ROUNDS(20), .RCNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .host_en(host_en),
        .qr_valid(qr_valid), .qr_ready(qr_ready),
        .qr_a(qr_a), .qr_b(qr_b), .qr_c(qr_c), .qr_d(qr_d),
        .round(round), .ff_valid(ff_valid), .ff_idx(ff_idx)
    );

    chacha_round_sched #(.ROUNDS(8), .RCNT_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(b8), .done(d8), .host_en(h8),
        .qr_valid(v8), .qr_ready(qr_ready),
        .qr_a(a8), .qr_b(bb8), .qr_c(c8), .qr_d(dd8),
        .round(r8), .ff_valid(f8), .ff_idx(fi8)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] exp_idx(input int n);
        int r, i, a, b, c, d;
        if (n < 8) return TBL[n];
        r = n / 4;
        i = n % 4;
        a = i;
        if (r % 2 == 0) begin
            b = 4 + i;
            c = 8 + i;
            d = 12 + i;
        end else begin
            b = 4 + ((i + 1) % 4);
            c = 8 + ((i + 2) % 4);
            d = 12 + ((i + 3) % 4);
        end
        return {4'(a), 4'(b), 4'(c), 4'(d)};
    endfunction

    task automatic run_block(input bit rnd, input bit hold,
                             input int abort_at, input bit chk8);
        int nx = 0, stalls = 0, dcnt = 0, dcyc = 0, ffc = 0;
        int ffe = 0, ixe = 0, rde = 0, ste = 0, n8 = 0, d8cyc = 0;
        logic [15:0] prev, got;
        bit pend = 0;
        bit fin = 0;
        qr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            qr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            got = {qr_a, qr_b, qr_c, qr_d};
            if (pend && got !== prev) ste++;
            if (v8 && qr_ready) n8++;
            if (d8 && d8cyc == 0) d8cyc = cyc;
            if (qr_valid) begin
                if (got !== exp_idx(nx)) ixe++;
                if (round !== 5'(nx / 4)) rde++;
                if (qr_ready) begin
                    nx++;
                    pend = 0;
                end else begin
                    stalls++;
                    pend = 1;
                    prev = got;
                end
            end
            if (ff_valid) begin
                if (ff_idx !== 4'(ffc)) ffe++;
                ffc++;
            end
            if (done) begin
                dcnt++;
                dcyc = cyc;
            end
            if (abort_at != 0 && nx == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_host_en", host_en, 1);
                chk("abort_done", done, 0);
                chk("abort_qr_valid", qr_valid, 0);
                chk("abort_round", round, 0);
                chk("abort_no_done_before", dcnt, 0);
                rst_n = 1'b1;
                return;
            end
            if (dcnt > 0 && cyc == dcyc + 1) begin
                chk("post_done_host_en", host_en, 1);
                chk("post_done_busy", busy, 0);
                chk("post_done_round", round, 0);
                if (hold) begin
                    @(negedge clk);
                    chk("hold_restart_busy", busy, 1);
                    chk("hold_restart_valid", qr_valid, 1);
                end
                fin = 1;
            end
        end
        chk("finished", fin, 1);
        chk("xfers", nx, 80);
        chk("done_count", dcnt, 1);
        chk("done_cycle", dcyc, 80 + stalls + FFN + 1);
        chk("ff_count", ffc, FFN);
        chk("ff_idx_seq_errs", ffe, 0);
        chk("idx_errs", ixe, 0);
        chk("round_errs", rde, 0);
        chk("stable_errs", ste, 0);
        if (chk8) begin
            chk("r8_xfers", n8, 32);
            chk("r8_done_cycle", d8cyc, 32 + FFN + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        qr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_host_en", host_en, 1);
        chk("rst_qr_valid", qr_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_round", round, 0);
        chk("rst_ff_valid", ff_valid, 0);
        chk("rst_ff_idx", ff_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_block(1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        run_block(1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);

        run_block(1'b0, 1'b1, 0, 1'b0);
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_busy", busy, 0);
        chk("rst2_host_en", host_en, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_block(1'b0, 1'b0, 37, 1'b0);
        @(negedge clk);
        run_block(1'b0, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
